// File: rtl/acq_vp_ram_if.sv
// VME memory-viewport bus between the register block and the acquisition RAM.
interface acq_vp_ram_if #(parameter int ADDR_W = 16);
  logic [ADDR_W-1:0] VMEAddr;
  logic [15:0]       VMERdData;
  logic [15:0]       VMEWrData;
  logic              VMERdMem;
  logic              VMEWrMem;
  logic              VMERdDone;
  logic              VMEWrDone;

  modport master (
    output VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
    input  VMERdData, VMERdDone, VMEWrDone
  );

  modport slave (
    input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
    output VMERdData, VMERdDone, VMEWrDone
  );
endinterface

// File: rtl/acq_vp_ram.sv
// Circular pre/post-trigger sample buffer in a single-port RAM, shared with a
// VME viewport that only gets the port on cycles without an acquisition write.
module acq_vp_ram #(
  parameter int ADDR_W = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  acq_vp_ram_if.slave       vme,
  input  logic [15:0]       AcqData,
  input  logic              AcqValid,
  input  logic              Arm,
  input  logic              Trigger,
  input  logic [ADDR_W-1:0] PostTrigCnt,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] TrigAddr
);
  typedef enum logic [1:0] {IDLE, PRETRIG, POSTTRIG, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt, trig_addr_nxt;
  logic [ADDR_W-1:0] post_n, post_n_nxt, post_cnt, post_cnt_nxt;
  logic              acq_wr, acq_active;

  logic              rd_pend, wr_pend, exec_rd, exec_wr;
  logic [ADDR_W-1:0] rd_addr, wr_addr, ram_addr;
  logic [15:0]       wr_data, ram_din, ram_q, rd_hold;
  logic              ram_we, rd_done, wr_done;

  logic [15:0]       mem [2**ADDR_W];

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    trig_addr_nxt = TrigAddr;
    post_n_nxt    = post_n;
    post_cnt_nxt  = post_cnt;
    acq_wr        = 1'b0;
    if (Arm) begin
      state_nxt    = PRETRIG;
      wr_ptr_nxt   = '0;
      post_cnt_nxt = '0;
    end else begin
      case (state)
        PRETRIG: begin
          if (Trigger) begin
            trig_addr_nxt = wr_ptr;
            post_n_nxt    = PostTrigCnt;
            post_cnt_nxt  = '0;
            if (PostTrigCnt == '0) begin
              state_nxt = DONE;
            end else begin
              state_nxt = POSTTRIG;
              // the trigger-cycle sample is the first post-trigger sample
              if (AcqValid) begin
                acq_wr       = 1'b1;
                wr_ptr_nxt   = wr_ptr + 1'b1;
                post_cnt_nxt = ADDR_W'(1);
                if (PostTrigCnt == ADDR_W'(1)) state_nxt = DONE;
              end
            end
          end else if (AcqValid) begin
            acq_wr     = 1'b1;
            wr_ptr_nxt = wr_ptr + 1'b1;
          end
        end
        POSTTRIG: begin
          if (AcqValid) begin
            acq_wr       = 1'b1;
            wr_ptr_nxt   = wr_ptr + 1'b1;
            post_cnt_nxt = post_cnt + 1'b1;
            if (post_cnt_nxt == post_n) state_nxt = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // viewport yields whenever a sample is offered while capturing
  assign acq_active = AcqValid && (state == PRETRIG || state == POSTTRIG);
  assign exec_wr    = wr_pend && !acq_active;
  assign exec_rd    = rd_pend && !wr_pend && !acq_active;

  assign ram_we   = acq_wr || exec_wr;
  assign ram_addr = acq_wr ? wr_ptr : (exec_wr ? wr_addr : rd_addr);
  assign ram_din  = acq_wr ? AcqData : wr_data;

  always_ff @(posedge Clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_q <= mem[ram_addr];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      TrigAddr <= '0;
      post_n   <= '0;
      post_cnt <= '0;
      rd_pend  <= 1'b0;
      wr_pend  <= 1'b0;
      rd_addr  <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_done  <= 1'b0;
      wr_done  <= 1'b0;
      rd_hold  <= '0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      TrigAddr <= trig_addr_nxt;
      post_n   <= post_n_nxt;
      post_cnt <= post_cnt_nxt;
      // a fresh strobe replaces whatever was queued
      if (vme.VMERdMem) begin
        rd_pend <= 1'b1;
        rd_addr <= vme.VMEAddr;
      end else if (exec_rd) begin
        rd_pend <= 1'b0;
      end
      if (vme.VMEWrMem) begin
        wr_pend <= 1'b1;
        wr_addr <= vme.VMEAddr;
        wr_data <= vme.VMEWrData;
      end else if (exec_wr) begin
        wr_pend <= 1'b0;
      end
      rd_done <= exec_rd;
      wr_done <= exec_wr;
      if (rd_done) rd_hold <= ram_q;
    end
  end

  assign vme.VMERdData = rd_done ? ram_q : rd_hold;
  assign vme.VMERdDone = rd_done;
  assign vme.VMEWrDone = wr_done;
  assign Busy          = (state == PRETRIG) || (state == POSTTRIG);
  assign Done          = (state == DONE);
endmodule

// File: tb/tb_acq_vp_ram.sv
// Two buffers (16-bit and 4-bit address) driven in lockstep, each checked every
// cycle against a behavioural model, plus hand-computed spot values.
module tb_acq_vp_ram;
  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] acq_data, post_cnt, vaddr, wdata;
  logic        acq_valid, arm, trigger, rd, wr;
  logic        busy0, done0, busy1, done1;
  logic [15:0] taddr0;
  logic [3:0]  taddr1;
  logic [15:0] r0, r1;

  int nvec = 0;
  int nbad = 0;

  always #5 Clk = ~Clk;

  acq_vp_ram_if #(.ADDR_W(16)) bus0 ();
  acq_vp_ram_if #(.ADDR_W(4))  bus1 ();

  assign bus0.VMEAddr   = vaddr;
  assign bus0.VMEWrData = wdata;
  assign bus0.VMERdMem  = rd;
  assign bus0.VMEWrMem  = wr;
  assign bus1.VMEAddr   = vaddr[3:0];
  assign bus1.VMEWrData = wdata;
  assign bus1.VMERdMem  = rd;
  assign bus1.VMEWrMem  = wr;

  acq_vp_ram #(.ADDR_W(16)) u_dut0 (
    .Clk(Clk), .Rst(Rst), .vme(bus0), .AcqData(acq_data), .AcqValid(acq_valid),
    .Arm(arm), .Trigger(trigger), .PostTrigCnt(post_cnt),
    .Busy(busy0), .Done(done0), .TrigAddr(taddr0)
  );
  acq_vp_ram #(.ADDR_W(4)) u_dut1 (
    .Clk(Clk), .Rst(Rst), .vme(bus1), .AcqData(acq_data), .AcqValid(acq_valid),
    .Arm(arm), .Trigger(trigger), .PostTrigCnt(post_cnt[3:0]),
    .Busy(busy1), .Done(done1), .TrigAddr(taddr1)
  );

  task automatic check(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model: state 0 idle, 1 pre-trigger, 2 post-trigger, 3 done
  int st[2], wp[2], ta[2], nn[2], cnt[2], ra[2], wa[2], wd[2], rdat[2];
  bit rp[2], wpd[2], rdn[2], wdn[2];
  int msk[2] = '{32'hFFFF, 32'hF};
  logic [15:0] mram [int];

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int  base = d << 16;
      bit  blk  = acq_valid && (st[d] == 1 || st[d] == 2);
      bit  e_rd, e_wr;
      if (Rst) begin
        st[d] = 0; wp[d] = 0; ta[d] = 0; nn[d] = 0; cnt[d] = 0;
        rp[d] = 0; wpd[d] = 0; rdat[d] = 0; rdn[d] = 0; wdn[d] = 0;
      end else begin
        e_wr = wpd[d] && !blk;
        e_rd = rp[d] && !wpd[d] && !blk;
        rdn[d] = e_rd;
        wdn[d] = e_wr;
        if (e_rd && mram.exists(base + ra[d])) rdat[d] = int'(mram[base + ra[d]]);
        if (e_wr) mram[base + wa[d]] = wd[d][15:0];
        if (rd) begin rp[d] = 1; ra[d] = int'(vaddr) & msk[d]; end
        else if (e_rd) rp[d] = 0;
        if (wr) begin wpd[d] = 1; wa[d] = int'(vaddr) & msk[d]; wd[d] = int'(wdata); end
        else if (e_wr) wpd[d] = 0;
        if (arm) begin
          st[d] = 1; wp[d] = 0; cnt[d] = 0;
        end else if (st[d] == 1 && trigger) begin
          ta[d] = wp[d];
          nn[d] = int'(post_cnt) & msk[d];
          cnt[d] = 0;
          if (nn[d] == 0) st[d] = 3;
          else begin
            st[d] = 2;
            if (acq_valid) begin
              mram[base + wp[d]] = acq_data;
              wp[d] = (wp[d] + 1) & msk[d];
              cnt[d] = 1;
              if (cnt[d] == nn[d]) st[d] = 3;
            end
          end
        end else if ((st[d] == 1 || st[d] == 2) && acq_valid) begin
          mram[base + wp[d]] = acq_data;
          wp[d] = (wp[d] + 1) & msk[d];
          if (st[d] == 2) begin
            cnt[d] = cnt[d] + 1;
            if (cnt[d] == nn[d]) st[d] = 3;
          end
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge Clk);
      model_step();
      #1;
      for (int d = 0; d < 2; d++) begin
        check($sformatf("busy%0d", d), d ? int'(busy1) : int'(busy0), int'(st[d] == 1 || st[d] == 2));
        check($sformatf("done%0d", d), d ? int'(done1) : int'(done0), int'(st[d] == 3));
        check($sformatf("trigaddr%0d", d), d ? int'(taddr1) : int'(taddr0), ta[d]);
        check($sformatf("rddone%0d", d), d ? int'(bus1.VMERdDone) : int'(bus0.VMERdDone), int'(rdn[d]));
        check($sformatf("wrdone%0d", d), d ? int'(bus1.VMEWrDone) : int'(bus0.VMEWrDone), int'(wdn[d]));
        check($sformatf("rddata%0d", d), d ? int'(bus1.VMERdData) : int'(bus0.VMERdData), rdat[d]);
      end
    end
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic vread(input logic [15:0] a, output logic [15:0] d0, output logic [15:0] d1);
    vaddr = a; rd = 1'b1; tick(); rd = 1'b0; tick();
    d0 = bus0.VMERdData; d1 = bus1.VMERdData;
  endtask

  initial begin
    Rst = 1'b1; acq_data = '0; acq_valid = 1'b0; arm = 1'b0; trigger = 1'b0;
    post_cnt = '0; vaddr = '0; wdata = '0; rd = 1'b0; wr = 1'b0;
    tick(); tick();
    check("rst_busy", int'(busy0), 0);
    check("rst_trigaddr", int'(taddr0), 0);
    check("rst_rddata", int'(bus0.VMERdData), 0);
    Rst = 1'b0;
    tick();

    // 1: viewport write then read while idle
    vaddr = 16'h0010; wdata = 16'hBEEF; wr = 1'b1; tick(); wr = 1'b0; tick();
    check("t1_wrdone", int'(bus0.VMEWrDone), 1);
    tick();
    vaddr = 16'h0010; rd = 1'b1; tick(); rd = 1'b0;
    check("t1_rddone_early", int'(bus0.VMERdDone), 0);
    tick();
    check("t1_rddone", int'(bus0.VMERdDone), 1);
    check("t1_rddata", int'(bus0.VMERdData), 16'hBEEF);

    // 2: 10 pre-trigger samples, trigger on sample 10 with 4 post samples
    arm = 1'b1; tick(); arm = 1'b0;
    acq_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      acq_data = 16'(i);
      trigger = (i == 10); post_cnt = 16'd4;
      tick();
      if (i == 12) check("t2_busy_mid", int'(busy0), 1);
    end
    trigger = 1'b0; acq_valid = 1'b0;
    check("t2_done", int'(done0), 1);
    check("t2_busy", int'(busy0), 0);
    check("t2_trigaddr", int'(taddr0), 10);
    vread(16'd12, r0, r1);
    check("t2_ram12", int'(r0), 12);

    // 3: wrap in the 16-deep buffer
    arm = 1'b1; tick(); arm = 1'b0;
    acq_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin acq_data = 16'(i); tick(); end
    acq_valid = 1'b0; trigger = 1'b1; post_cnt = 16'd2; tick(); trigger = 1'b0;
    acq_valid = 1'b1; acq_data = 16'd20; tick(); acq_data = 16'd21; tick(); acq_valid = 1'b0;
    check("t3_done", int'(done1), 1);
    check("t3_trigaddr_small", int'(taddr1), 4);
    check("t3_trigaddr_big", int'(taddr0), 20);
    vread(16'd4, r0, r1); check("t3_ram4", int'(r1), 20);
    vread(16'd5, r0, r1); check("t3_ram5", int'(r1), 21);
    vread(16'd3, r0, r1); check("t3_ram3", int'(r1), 19);

    // 4: read strobe at the start of a 5-sample burst
    arm = 1'b1; tick(); arm = 1'b0;
    acq_valid = 1'b1; acq_data = 16'd100; vaddr = 16'd5; rd = 1'b1; tick(); rd = 1'b0;
    for (int i = 1; i < 5; i++) begin acq_data = 16'(100 + i); tick(); end
    acq_valid = 1'b0;
    check("t4_rddone_stalled", int'(bus0.VMERdDone), 0);
    tick();
    check("t4_rddone", int'(bus0.VMERdDone), 1);
    check("t4_rddata_big", int'(bus0.VMERdData), 5);
    check("t4_rddata_small", int'(bus1.VMERdData), 21);
    vread(16'd4, r0, r1);
    check("t4_ram4", int'(r0), 104);

    // 4b: write and read both queued during a burst; write goes first
    acq_valid = 1'b1; acq_data = 16'h0055; vaddr = 16'd7; wdata = 16'h0077;
    wr = 1'b1; rd = 1'b1; tick(); wr = 1'b0; rd = 1'b0;
    acq_data = 16'h0056; tick(); acq_data = 16'h0057; tick(); acq_valid = 1'b0;
    tick();
    check("t4b_wrdone", int'(bus0.VMEWrDone), 1);
    check("t4b_rd_waits", int'(bus0.VMERdDone), 0);
    tick();
    check("t4b_rddone", int'(bus0.VMERdDone), 1);
    check("t4b_rddata", int'(bus0.VMERdData), 16'h0077);

    // 5: Arm outranks Trigger; zero post count finishes without writing
    arm = 1'b1; trigger = 1'b1; post_cnt = 16'd7; tick(); arm = 1'b0; trigger = 1'b0;
    check("t5_busy", int'(busy0), 1);
    check("t5_trigaddr_kept", int'(taddr0), 20);
    trigger = 1'b1; post_cnt = 16'd0; acq_valid = 1'b1; acq_data = 16'hDEAD; tick();
    trigger = 1'b0; acq_valid = 1'b0;
    check("t5_done", int'(done0), 1);
    check("t5_trigaddr", int'(taddr0), 0);
    vread(16'd0, r0, r1);
    check("t5_ram0", int'(r0), 100);

    // 6: reset during post-trigger with a read queued
    arm = 1'b1; tick(); arm = 1'b0;
    trigger = 1'b1; post_cnt = 16'd10; acq_valid = 1'b1; acq_data = 16'h0600; tick();
    trigger = 1'b0; acq_data = 16'h0601; vaddr = 16'd1; rd = 1'b1; tick(); rd = 1'b0;
    check("t6_busy", int'(busy0), 1);
    Rst = 1'b1; acq_valid = 1'b0; tick(); Rst = 1'b0;
    check("t6_busy_rst", int'(busy0), 0);
    check("t6_done_rst", int'(done0), 0);
    check("t6_trigaddr_rst", int'(taddr0), 0);
    check("t6_rddata_rst", int'(bus0.VMERdData), 0);
    tick(); tick(); tick();
    check("t6_no_rddone", int'(bus0.VMERdDone), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
